// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game flow controller and its surroundings.
// master drives keyboard/frame/play status; slave is the controller itself.
interface game_flow_ctrl_if #(
  parameter int KEY_W = 8
);
  logic             frame_tick_i;
  logic [KEY_W-1:0] keycode_i;
  logic             refresh_en_i;
  logic             refresh_done_i;
  logic             game_over_trigger_i;
  logic [2:0]       outstate_o;
  logic             loadplat_o;
  logic             state_entry_o;
  logic             refresh_timeout_o;

  modport master (
    output frame_tick_i, keycode_i, refresh_en_i, refresh_done_i, game_over_trigger_i,
    input  outstate_o, loadplat_o, state_entry_o, refresh_timeout_o
  );

  modport slave (
    input  frame_tick_i, keycode_i, refresh_en_i, refresh_done_i, game_over_trigger_i,
    output outstate_o, loadplat_o, state_entry_o, refresh_timeout_o
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow FSM (menu/load/game/pause/refresh/over) driven by key press edges and frame ticks.
// One-cycle registered latency from inputs to every output; no backpressure, inputs sampled each cycle.
module game_flow_ctrl #(
  parameter int               KEY_W       = 8,
  parameter logic [KEY_W-1:0] KEY_START   = 8'd44,
  parameter logic [KEY_W-1:0] KEY_ESC     = 8'd41,
  parameter int               CNT_W       = 8,
  parameter int               LOAD_FRAMES = 60,
  parameter int               OVER_FRAMES = 30,
  parameter int               REFRESH_MAX = 16
) (
  input logic              Clock,
  input logic              Reset,
  game_flow_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_MAIN    = 3'b000,
    S_LOAD    = 3'b001,
    S_GAME    = 3'b010,
    S_PAUSE   = 3'b011,
    S_REFRESH = 3'b100,
    S_INIT    = 3'b101,
    S_OVER    = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(LOAD_FRAMES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_MAX - 1);
  localparam logic [CNT_W-1:0] OVER_MIN     = CNT_W'(OVER_FRAMES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] key_prev_q;
  logic             state_entry_q;
  logic             refresh_timeout_q, refresh_timeout_d;

  logic press_start, press_esc, any_press, last_tick;

  // A key only counts on the cycle it first differs from the previous sample.
  assign press_start = (bus.keycode_i == KEY_START) && (key_prev_q != KEY_START);
  assign press_esc   = (bus.keycode_i == KEY_ESC) && (key_prev_q != KEY_ESC);
  assign any_press   = (bus.keycode_i != '0) && (bus.keycode_i != key_prev_q);
  assign last_tick   = bus.frame_tick_i;

  always_comb begin
    state_d           = state_q;
    refresh_timeout_d = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_MAIN;
      S_MAIN:  if (press_start) state_d = S_LOAD;
      S_LOAD:  if (last_tick && cnt_q == LOAD_LAST) state_d = S_GAME;
      S_GAME: begin
        if (press_esc)                    state_d = S_PAUSE;
        else if (bus.game_over_trigger_i) state_d = S_OVER;
        else if (bus.refresh_en_i)        state_d = S_REFRESH;
      end
      S_PAUSE: if (any_press) state_d = S_GAME;
      S_REFRESH: begin
        // refresh_done beats a coincident timeout, suppressing the pulse.
        if (bus.refresh_done_i) begin
          state_d = S_GAME;
        end else if (last_tick && cnt_q == REFRESH_LAST) begin
          state_d           = S_GAME;
          refresh_timeout_d = 1'b1;
        end
      end
      S_OVER:  if (press_esc && cnt_q >= OVER_MIN) state_d = S_MAIN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q           <= S_INIT;
      cnt_q             <= '0;
      key_prev_q        <= '0;
      state_entry_q     <= 1'b0;
      refresh_timeout_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      key_prev_q        <= bus.keycode_i;
      state_entry_q     <= (state_d != state_q);
      refresh_timeout_q <= refresh_timeout_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (bus.frame_tick_i && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.outstate_o        = state_q;
  assign bus.loadplat_o        = (state_q == S_LOAD);
  assign bus.state_entry_o     = state_entry_q;
  assign bus.refresh_timeout_o = refresh_timeout_q;

endmodule
